// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        AXI_IDLE      = 2'd0,
        AXI_IM_WAIT   = 2'd1,
        AXI_DM_WAIT   = 2'd2,
        AXI_BOTH_WAIT = 2'd3
    } axi_wait_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bus; PIPE_STALL_CNT_EN adds the stall counters
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    // memory handshakes
    logic                  im_req;
    logic                  im_done;
    logic                  dm_req;
    logic                  dm_done;
    // EX stage
    logic                  E_jb;
    logic                  E_is_load;
    logic [REG_ADDR_W-1:0] E_rd;
    // ID stage
    logic [REG_ADDR_W-1:0] D_rs1;
    logic [REG_ADDR_W-1:0] D_rs2;
    logic                  D_rs1_used;
    logic                  D_rs2_used;
    // controls back to the pipeline
    logic                  stall_CPU;
    logic                  stall_AXI;
    logic                  jb;
    logic                  pc_we;
    logic                  E_bubble;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           lu_cnt;

    modport master (
        output im_req, im_done, dm_req, dm_done,
        output E_jb, E_is_load, E_rd, D_rs1, D_rs2, D_rs1_used, D_rs2_used,
        input  stall_CPU, stall_AXI, jb, pc_we, E_bubble, stall_cnt, lu_cnt
    );
    modport slave (
        input  im_req, im_done, dm_req, dm_done,
        input  E_jb, E_is_load, E_rd, D_rs1, D_rs2, D_rs1_used, D_rs2_used,
        output stall_CPU, stall_AXI, jb, pc_we, E_bubble, stall_cnt, lu_cnt
    );
`else
    modport master (
        output im_req, im_done, dm_req, dm_done,
        output E_jb, E_is_load, E_rd, D_rs1, D_rs2, D_rs1_used, D_rs2_used,
        input  stall_CPU, stall_AXI, jb, pc_we, E_bubble
    );
    modport slave (
        input  im_req, im_done, dm_req, dm_done,
        input  E_jb, E_is_load, E_rd, D_rs1, D_rs2, D_rs1_used, D_rs2_used,
        output stall_CPU, stall_AXI, jb, pc_we, E_bubble
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// rtl/pipe_hazard_ctrl_load_use_det.sv - combinational load-use hazard detector
module load_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic                  e_is_load_i,
    input  logic [REG_ADDR_W-1:0] e_rd_i,
    input  logic [REG_ADDR_W-1:0] d_rs1_i,
    input  logic [REG_ADDR_W-1:0] d_rs2_i,
    input  logic                  d_rs1_used_i,
    input  logic                  d_rs2_used_i,
    output logic                  hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        rs1_hit  = d_rs1_used_i && (d_rs1_i == e_rd_i);
        rs2_hit  = d_rs2_used_i && (d_rs2_i == e_rd_i);
        hazard_o = e_is_load_i && (e_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - memory-wait FSM, deferred branch flush and load-use stall; PIPE_STALL_CNT_EN adds counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    axi_wait_e state_q, state_d;
    logic      jb_pend_q, jb_pend_d;
    logic      im_wait;
    logic      dm_wait;
    logic      stall_axi;
    logic      lu_hazard;
    logic      jb_fire;
    logic      stall_cpu;

    load_use_det u_load_use_det (
        .e_is_load_i  (bus.E_is_load),
        .e_rd_i       (bus.E_rd),
        .d_rs1_i      (bus.D_rs1),
        .d_rs2_i      (bus.D_rs2),
        .d_rs1_used_i (bus.D_rs1_used),
        .d_rs2_used_i (bus.D_rs2_used),
        .hazard_o     (lu_hazard)
    );

    // A request completing in its own cycle costs nothing; only the rest open a wait
    always_comb begin
        im_wait = bus.im_req && !bus.im_done;
        dm_wait = bus.dm_req && !bus.dm_done;
    end

    // Wait-state transitions; new requests are only accepted from IDLE, stray dones are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            AXI_IDLE: begin
                if (im_wait && dm_wait) state_d = AXI_BOTH_WAIT;
                else if (im_wait)       state_d = AXI_IM_WAIT;
                else if (dm_wait)       state_d = AXI_DM_WAIT;
            end
            AXI_IM_WAIT: begin
                if (bus.im_done) state_d = AXI_IDLE;
            end
            AXI_DM_WAIT: begin
                if (bus.dm_done) state_d = AXI_IDLE;
            end
            AXI_BOTH_WAIT: begin
                case ({bus.im_done, bus.dm_done})
                    2'b10:   state_d = AXI_DM_WAIT;
                    2'b01:   state_d = AXI_IM_WAIT;
                    2'b11:   state_d = AXI_IDLE;
                    default: state_d = AXI_BOTH_WAIT;
                endcase
            end
            default: state_d = AXI_IDLE;
        endcase
    end

    // Stall, flush and PC control; a branch seen during a memory stall is held until release
    always_comb begin
        stall_axi = (state_q != AXI_IDLE) || im_wait || dm_wait;
        jb_fire   = !stall_axi && (bus.E_jb || jb_pend_q);
        stall_cpu = lu_hazard && !jb_fire;
        jb_pend_d = jb_pend_q;
        if (stall_axi && bus.E_jb) jb_pend_d = 1'b1;
        else if (jb_fire)          jb_pend_d = 1'b0;
    end

    assign bus.stall_AXI = stall_axi;
    assign bus.stall_CPU = stall_cpu;
    assign bus.jb        = jb_fire;
    assign bus.pc_we     = !(stall_cpu || stall_axi) || jb_fire;
    assign bus.E_bubble  = stall_cpu && !stall_axi;

    // FSM and pending-flush registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= AXI_IDLE;
            jb_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            jb_pend_q <= jb_pend_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] lu_cnt_q, lu_cnt_d;

    // Free-running stall statistics; natural 32-bit wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_axi};
        lu_cnt_d    = lu_cnt_q + {31'd0, stall_cpu};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.lu_cnt    = lu_cnt_q;
`endif

endmodule
